// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port synchronous dmem (12-bit word address, 32-bit data,
// 1-cycle read latency) between the CPU load/store port and a peripheral port.
// Arbitration uses fixed CPU priority, with two exceptions:
//   - a starvation timer forces a peripheral grant after MAX_WAIT denied cycles;
//   - a locked peripheral burst may hold the memory for up to BURST_MAX cycles.
//
// Handshake: a requester holds req (and its addr/wdata/wren) stable until it
// sees its grant in the same cycle (cpu_stall low / per_gnt high). A granted
// read returns one cycle later as rvalid with rdata. Writes return nothing.
//
// Optional build macro DMEM_ARB_WRITE_GUARD_EN: peripheral writes outside the
// top 1K-word window (per_addr[11:10] != 2'b11) are granted but not written.
// In that build a sticky per_wr_err output reports the blocked write.
//
// arb_state exposes the arbiter FSM state for debug.

module dmem_port_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        per_req,
    input  logic        per_wren,
    input  logic [11:0] per_addr,
    input  logic [31:0] per_wdata,
    input  logic        per_lock,
    output logic        per_gnt,
    output logic        per_rvalid,
    output logic [31:0] per_rdata,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [1:0]  arb_state
`ifdef DMEM_ARB_WRITE_GUARD_EN
    ,
    output logic        per_wr_err
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_OWN   = 2'd1,
        PER_OWN   = 2'd2,
        PER_BURST = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

    state_t      state;
    logic [3:0]  burst_cnt;
    logic [7:0]  wait_cnt;
    logic        rd_valid;
    logic        rd_owner;   // 0 = CPU, 1 = peripheral

    logic        burst_hold;
    logic        starve;
    logic        cpu_grant;
    logic        per_grant;
    logic        per_wr_block;

    // Grant decision: burst lock, then starvation, then CPU, then peripheral.
    // Grants are masked while reset is asserted so the memory is never driven.
    always_comb begin
        burst_hold = (state == PER_BURST) && per_req && per_lock &&
                     (burst_cnt < BURST_MAX_C);
        starve     = (wait_cnt == MAX_WAIT_C) && per_req;
        per_grant  = ~reset & (burst_hold | starve | (per_req & ~cpu_req));
        cpu_grant  = ~reset & cpu_req & ~burst_hold & ~starve;
    end

`ifdef DMEM_ARB_WRITE_GUARD_EN
    // A peripheral write outside the top 1K-word window is suppressed.
    always_comb begin
        per_wr_block = per_grant & per_wren & (per_addr[11:10] != 2'b11);
    end
`else
    // The peripheral may write anywhere.
    always_comb begin
        per_wr_block = 1'b0;
    end
`endif

    // Memory-side mux: the granted requester drives the dmem, the CPU by default.
    always_comb begin
        mem_address = per_grant ? per_addr  : cpu_addr;
        mem_data    = per_grant ? per_wdata : cpu_wdata;
        if (cpu_grant)
            mem_wren = cpu_wren;
        else if (per_grant)
            mem_wren = per_wren & ~per_wr_block;
        else
            mem_wren = 1'b0;
    end

    // Requester-side outputs: stall and grant now, read return from the tag.
    always_comb begin
        cpu_stall  = cpu_req & ~cpu_grant;
        per_gnt    = per_grant;
        cpu_rvalid = rd_valid & ~rd_owner;
        per_rvalid = rd_valid & rd_owner;
        cpu_rdata  = cpu_rvalid ? mem_q : 32'h0;
        per_rdata  = per_rvalid ? mem_q : 32'h0;
        arb_state  = state;
    end

    // Arbiter FSM with its burst counter, starvation counter and read tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
            rd_valid  <= 1'b0;
            rd_owner  <= 1'b0;
        end else begin
            if (cpu_grant)
                state <= CPU_OWN;
            else if (per_grant)
                state <= per_lock ? PER_BURST : PER_OWN;
            else
                state <= IDLE;

            // Count locked peripheral grants. Once the count reaches BURST_MAX
            // the lock is ignored for a cycle. If the peripheral still wins
            // that cycle, the burst restarts at 1.
            if (per_grant && per_lock) begin
                if ((state == PER_BURST) && (burst_cnt < BURST_MAX_C))
                    burst_cnt <= burst_cnt + 4'd1;
                else
                    burst_cnt <= 4'd1;
            end else begin
                burst_cnt <= 4'd0;
            end

            // Count consecutive denied peripheral cycles, saturating.
            if (per_req && !per_grant) begin
                if (wait_cnt < MAX_WAIT_C)
                    wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end

            rd_valid <= (cpu_grant & ~cpu_wren) | (per_grant & ~per_wren);
            rd_owner <= per_grant;
        end
    end

`ifdef DMEM_ARB_WRITE_GUARD_EN
    // Sticky flag for a blocked peripheral write, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            per_wr_err <= 1'b0;
        else if (per_wr_block)
            per_wr_err <= 1'b1;
    end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous dmem (12-bit word address, 32-bit data, 1-cycle read latency) between two requesters.
- Requester 0: processor load/store port. Requester 1: peripheral port (board/display engine or host loader).
- Sits between the processor's dmem outputs and the dmem instance.
- Fixed CPU priority, anti-starvation timer and bounded peripheral burst lock.

Parameters:
- MAX_WAIT, 8: consecutive denied peripheral cycles before the peripheral is forced a grant (1..255).
- BURST_MAX, 4: maximum consecutive peripheral grants while per_lock is held (1..15).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request, valid this cycle.
- cpu_wren  in  1  1 = store, 0 = load.
- cpu_addr  in  12  CPU word address.
- cpu_wdata  in  32  CPU store data.
- cpu_stall  out  1  CPU request not granted this cycle; CPU holds request.
- cpu_rvalid  out  1  load data valid on cpu_rdata.
- cpu_rdata  out  32  load return data.
- per_req  in  1  peripheral request.
- per_wren  in  1  peripheral write enable.
- per_addr  in  12  peripheral word address.
- per_wdata  in  32  peripheral write data.
- per_lock  in  1  peripheral requests burst ownership.
- per_gnt  out  1  peripheral request granted this cycle.
- per_rvalid  out  1  peripheral read data valid.
- per_rdata  out  32  peripheral read return data.
- mem_address  out  12  to dmem address.
- mem_data  out  32  to dmem data.
- mem_wren  out  1  to dmem write enable.
- mem_q  in  32  from dmem q.

Behaviour:
- State machine (registered): IDLE, CPU_OWN, PER_OWN, PER_BURST.
- Grant is combinational from state and requests. At most one grant per cycle.
- Grant decision, in priority order:
  1. In PER_BURST with per_req=1, per_lock=1 and burst_cnt<BURST_MAX: peripheral wins.
  2. Else if wait_cnt==MAX_WAIT and per_req=1: peripheral wins.
  3. Else if cpu_req=1: CPU wins.
  4. Else if per_req=1: peripheral wins.
  5. Else no grant.
- Outputs from the grant:
  - cpu_stall = cpu_req & ~cpu_grant.
  - per_gnt = per_grant.
  - mem_address/mem_data come from the granted requester. With no grant they come from the CPU fields.
  - mem_wren = granted requester's wren. It is 0 when there is no grant.
- Next state:
  - CPU grant -> CPU_OWN.
  - Peripheral grant with per_lock=1 -> PER_BURST.
  - Peripheral grant with per_lock=0 -> PER_OWN.
  - No grant -> IDLE.
- burst_cnt:
  - Increments on each peripheral grant in PER_BURST or on entry to it.
  - Clears on any non-peripheral cycle.
  - At BURST_MAX, the lock is ignored for one cycle. If cpu_req=1 the CPU is granted; otherwise the burst may restart.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when per_req=1 and per_gnt=0.
  - Clears on per_gnt or when per_req=0.
- Read return:
  - A granted read with wren=0 sets a registered tag {valid, owner}.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_q. The other rdata holds 0.
  - Writes produce no rvalid.
  - Back-to-back reads return every cycle in grant order.
- Simultaneous first requests: CPU wins. The peripheral stalls and wait_cnt starts at 1 next cycle.
- Reset, asynchronous and effective immediately, including mid-burst:
  - State forced to IDLE; burst_cnt, wait_cnt and read tag cleared.
  - cpu_rvalid=0, per_rvalid=0, per_gnt=0, rdata outputs 0, mem_wren=0.
  - Any pending read return is dropped.
  - cpu_stall follows cpu_req after reset deasserts.

Optional Feature:
- Macro: DMEM_ARB_WRITE_GUARD_EN.
- When defined:
  - Peripheral writes with per_addr[11:10]!=2'b11 (outside the top 1K-word window) are granted but mem_wren is forced 0.
  - Sticky output per_wr_err (1 bit) is set. Cleared only by reset.
- When undefined:
  - The peripheral may write anywhere.
  - per_wr_err is absent from the port list.

Test Plan:
- CPU read alone: cpu_req=1, cpu_wren=0, cpu_addr=0x010, mem holds 0xDEADBEEF at 0x010 -> cpu_stall=0; next cycle cpu_rvalid=1 and cpu_rdata=0xDEADBEEF; per_rvalid=0.
- Simultaneous requests, MAX_WAIT=8: cpu_req and per_req held at 1 for 12 cycles -> CPU granted cycles 0-7; cycle 8 per_gnt=1 and cpu_stall=1; cycle 9 CPU granted again with wait_cnt restarting.
- Burst, BURST_MAX=4: per_req=per_lock=1, cpu_req=1 asserted during the burst -> per_gnt for 4 consecutive cycles; cpu_stall=1 for those 4; 5th cycle CPU granted.
- Write then read: peripheral writes 0x12345678 to 0xC05; CPU then reads 0xC05 -> cpu_rdata=0x12345678 one cycle after grant; no per_rvalid.
- Reset mid-burst: assert reset in burst cycle 2 while a peripheral read is outstanding -> per_gnt, per_rvalid and mem_wren drop to 0 immediately; after release, first grant goes to the CPU if cpu_req=1.
- Guard (DMEM_ARB_WRITE_GUARD_EN defined): peripheral write to 0x100 -> per_gnt=1, mem_wren=0, per_wr_err=1 and stays 1; a write to 0xC00 proceeds with mem_wren=1.
